// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, default sizes and address-limit helper for instr_loader.
package loader_pkg;
    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 12;
    localparam int DEF_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    function automatic logic [31:0] last_addr(input int aw);
        return (32'd1 << aw) - 32'd1;
    endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO with registered occupancy and combinational head output.
module instr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [PW:0]      cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= din;
    end

    assign dout  = mem[rp];
    assign full  = cnt == (PW+1)'(DEPTH);
    assign empty = cnt == '0;
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams a program into the processor instruction RAM while holding it in reset.
// Optional INSTR_LOADER_CHECKSUM_EN adds a running XOR of written words on load_checksum.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_start,
    input  logic [ADDRESS_WIDTH-1:0] load_base_addr,
    input  logic                     s_valid,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_last,
    output logic                     s_ready,
    output logic [ADDRESS_WIDTH-1:0] ram_init_wadrs,
    output logic [DATA_WIDTH-1:0]    ram_write_instruction,
    output logic                     ram_we,
    output logic                     initialize_instructions,
    output logic                     proc_reset,
    output logic                     load_done,
    output logic [ADDRESS_WIDTH:0]   load_count,
`ifdef INSTR_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    load_checksum,
`endif
    output logic                     load_overflow
);
    localparam logic [ADDRESS_WIDTH:0] LIMIT = (ADDRESS_WIDTH+1)'(last_addr(ADDRESS_WIDTH));

    state_t                 state, next_state;
    logic [ADDRESS_WIDTH:0] ptr, cnt;
    logic                   loaded, ovf, active, push, pop, exhausted, write, f_full, f_empty;
    logic [DATA_WIDTH:0]    f_dout;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum;
    assign load_checksum = csum;
`endif

    instr_fifo #(.WIDTH(DATA_WIDTH+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({s_last, s_data}),
        .dout  (f_dout),
        .full  (f_full),
        .empty (f_empty)
    );

    assign active    = state == LOAD || state == DRAIN;
    assign s_ready   = state == LOAD && !f_full;
    assign push      = s_valid && s_ready;
    assign pop       = active && !f_empty;
    // ptr carries one extra bit so stepping past the last address is visible without wrapping
    assign exhausted = ptr > LIMIT;
    assign write     = pop && !exhausted;

    always_comb begin
        next_state = state == IDLE  ? (load_start ? LOAD : IDLE) :
                     state == LOAD  ? ((push && s_last) ? DRAIN : LOAD) :
                     state == DRAIN ? ((pop && f_dout[DATA_WIDTH]) ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            loaded <= 1'b0;
            ovf    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum   <= '0;
`endif
        end else begin
            state <= next_state;
            if (state == DONE) loaded <= 1'b1;
            if (state == IDLE && load_start) begin
                ptr <= {1'b0, load_base_addr};
                cnt <= '0;
                ovf <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end else if (pop && exhausted) begin
                ovf <= 1'b1;
            end else if (write) begin
                ptr <= ptr + (ADDRESS_WIDTH+1)'(1);
                cnt <= cnt + (ADDRESS_WIDTH+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum <= csum ^ f_dout[DATA_WIDTH-1:0];
`endif
            end
        end
    end

    assign ram_we                  = write;
    assign ram_init_wadrs          = ptr[ADDRESS_WIDTH-1:0];
    assign ram_write_instruction   = write ? f_dout[DATA_WIDTH-1:0] : '0;
    assign initialize_instructions = active;
    assign proc_reset              = state != IDLE || !loaded || load_start;
    assign load_done               = state == DONE;
    assign load_count              = cnt;
    assign load_overflow           = ovf;
endmodule
